// File: rtl/psram_qspi_ctrl.sv
// QSPI initiator for a PSRAM: one request becomes one quad read (EBh) or quad write (38h) frame.
// The frame is paced by a period index; the CMD/ADDR/WAIT/DATA phases are derived from it.
module psram_qspi_ctrl #(
  parameter int DIV    = 1,
  parameter int CE_GAP = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [23:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        sck_o,
  output logic        ce_n_o,
  output logic [3:0]  dio_o,
  output logic [3:0]  dio_oe_o,
  input  logic [3:0]  dio_i
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = (CE_GAP > 1) ? $clog2(CE_GAP) : 1;

  typedef enum logic [1:0] {IDLE, FRAME, GAP, RESP} state_t;

  state_t      state_q;
  logic        wen_q, ph_q, sck_q, ce_n_q, ready_q, rvalid_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q, cap_q, rdata_q;
  logic [4:0]  per_q, last_q;
  logic [DW-1:0] div_q;
  logic [GW-1:0] gap_q;
  logic [3:0]  dout_q, doe_q;

  logic [4:0]  per_nx, nib;
  logic [7:0]  cmd;
  logic [2:0]  wj, rj;
  logic [3:0]  nx_o, nx_oe;
  logic [31:0] cap_nx;

  assign per_nx = per_q + 5'd1;

  always_comb begin
    nib = (req_size_i == 2'd0) ? 5'd2 : (req_size_i == 2'd1) ? 5'd4 : 5'd8;
  end

  // Pin values for the period about to start, and the capture of the period just ending.
  always_comb begin
    cmd    = wen_q ? 8'h38 : 8'hEB;
    wj     = 3'(per_nx - 5'd14);
    rj     = 3'(per_q - 5'd20);
    nx_o   = '0;
    nx_oe  = '0;
    cap_nx = cap_q;
    if (per_nx < 5'd8) begin
      nx_oe = 4'b0001;
      nx_o  = {3'b000, cmd[~per_nx[2:0]]};
    end else if (per_nx < 5'd14) begin
      nx_oe = 4'hF;
      nx_o  = addr_q[{3'(5'd13 - per_nx), 2'b00} +: 4];
    end else if (wen_q) begin
      nx_oe = 4'hF;
      nx_o  = wdata_q[{wj[2:1], ~wj[0], 2'b00} +: 4];
    end
    if (!wen_q && per_q >= 5'd20)
      cap_nx[{rj[2:1], ~rj[0], 2'b00} +: 4] = dio_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cap_q    <= '0;
      rdata_q  <= '0;
      per_q    <= '0;
      last_q   <= '0;
      div_q    <= '0;
      gap_q    <= '0;
      ph_q     <= 1'b0;
      sck_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      dout_q   <= '0;
      doe_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready_q && req_valid_i) begin
            ready_q <= 1'b0;
            wen_q   <= req_wen_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            last_q  <= 5'd13 + (req_wen_i ? 5'd0 : 5'd6) + nib;
            cap_q   <= '0;
            per_q   <= '0;
            div_q   <= '0;
            ph_q    <= 1'b0;
            sck_q   <= 1'b0;
            ce_n_q  <= 1'b0;
            doe_q   <= 4'b0001;
            dout_q  <= {3'b000, ~req_wen_i};   // MSB of EBh is 1, of 38h is 0
            state_q <= FRAME;
          end else begin
            ready_q <= 1'b1;
          end
        end
        FRAME: begin
          if (div_q == DW'(DIV - 1)) begin
            div_q <= '0;
            if (!ph_q) begin
              ph_q  <= 1'b1;
              sck_q <= 1'b1;
            end else begin
              ph_q  <= 1'b0;
              sck_q <= 1'b0;
              cap_q <= cap_nx;
              if (per_q == last_q) begin
                ce_n_q  <= 1'b1;
                doe_q   <= '0;
                dout_q  <= '0;
                rdata_q <= cap_nx;
                gap_q   <= '0;
                state_q <= GAP;
              end else begin
                per_q  <= per_nx;
                doe_q  <= nx_oe;
                dout_q <= nx_o;
              end
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        GAP: begin
          if (gap_q == GW'(CE_GAP - 1)) begin
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            rvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = rvalid_q;
  assign resp_rdata_o = rdata_q;
  assign sck_o        = sck_q;
  assign ce_n_o       = ce_n_q;
  assign dio_o        = dout_q;
  assign dio_oe_o     = doe_q;
endmodule

// File: tb/tb_psram_qspi_ctrl.sv
// Bench for psram_qspi_ctrl: two instances (DIV=1 and DIV=2) driven by a pin-level PSRAM model.
module tb_psram_qspi_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid[2], req_ready[2], req_wen[2], resp_valid[2], resp_ready[2];
  logic [23:0] req_addr[2];
  logic [1:0]  req_size[2];
  logic [31:0] req_wdata[2], resp_rdata[2];
  logic        sck[2], ce_n[2];
  logic [3:0]  dio_o[2], dio_oe[2], dio_i[2];

  psram_qspi_ctrl #(.DIV(1), .CE_GAP(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_wen_i(req_wen[0]), .req_addr_i(req_addr[0]), .req_size_i(req_size[0]),
    .req_wdata_i(req_wdata[0]), .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .sck_o(sck[0]), .ce_n_o(ce_n[0]), .dio_o(dio_o[0]),
    .dio_oe_o(dio_oe[0]), .dio_i(dio_i[0]));

  psram_qspi_ctrl #(.DIV(2), .CE_GAP(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_wen_i(req_wen[1]), .req_addr_i(req_addr[1]), .req_size_i(req_size[1]),
    .req_wdata_i(req_wdata[1]), .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .sck_o(sck[1]), .ce_n_o(ce_n[1]), .dio_o(dio_o[1]),
    .dio_oe_o(dio_oe[1]), .dio_i(dio_i[1]));

  int checks = 0, errors = 0;
  int act = 0;
  int lowcnt = 0, hirun = 0, last_gap = 0, bad_sck = 0, bad_rdy = 0;
  logic [7:0] capq[$];
  logic [7:0] mem[2][256];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // PSRAM pin model: logs {oe,o} at every sck rise and serves read nibbles decoded from the frame.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(posedge sck[g]) begin : dev
      int k;
      logic [7:0]  c;
      logic [23:0] a;
      logic [7:0]  b;
      if (!ce_n[g] && act == g) begin
        capq.push_back({dio_oe[g], dio_o[g]});
        k = capq.size() - 1;
        dio_i[g] = 4'($urandom);
        if (k >= 20) begin
          c = '0;
          a = '0;
          for (int n = 0; n < 8; n++) c = {c[6:0], capq[n][0]};
          for (int n = 8; n < 14; n++) a = {a[19:0], capq[n][3:0]};
          if (c == 8'hEB) begin
            b = mem[g][8'(a[7:0] + 8'((k - 20) / 2))];
            dio_i[g] = ((k - 20) % 2 == 0) ? b[7:4] : b[3:0];
          end
        end
      end
    end

    always @(negedge clk) begin
      if (act == g) begin
        if (!ce_n[g]) begin
          lowcnt++;
          if (hirun > 0) last_gap = hirun;
          hirun = 0;
        end else begin
          hirun++;
        end
        if (ce_n[g] && sck[g]) bad_sck++;
        if (req_ready[g] && (resp_valid[g] || !ce_n[g])) bad_rdy++;
      end
    end
  end

  task automatic txn(input int i, input logic wen, input logic [23:0] addr, input logic [1:0] size,
                     input logic [31:0] wdata, input logic hold_rr, input string tag,
                     output logic [31:0] rdata);
    logic [7:0]  expq[$];
    logic [7:0]  cmdv, by;
    logic [31:0] exp_rd;
    int nb, t, mism, dv;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    dv   = (i == 0) ? 1 : 2;
    cmdv = wen ? 8'h38 : 8'hEB;
    for (int b = 7; b >= 0; b--) expq.push_back({4'b0001, 3'b000, cmdv[b]});
    for (int n = 5; n >= 0; n--) expq.push_back({4'hF, addr[4*n +: 4]});
    if (!wen) for (int n = 0; n < 6; n++) expq.push_back(8'h00);
    exp_rd = '0;
    for (int k = 0; k < nb; k++) begin
      by = wen ? wdata[8*k +: 8] : mem[i][8'(addr[7:0] + 8'(k))];
      expq.push_back({wen ? 4'hF : 4'h0, by[7:4]});
      expq.push_back({wen ? 4'hF : 4'h0, by[3:0]});
      if (!wen) exp_rd[8*k +: 8] = by;
    end
    rdata = '0;
    act = i;
    @(negedge clk);
    capq.delete();
    lowcnt = 0;
    req_wen[i] = wen; req_addr[i] = addr; req_size[i] = size; req_wdata[i] = wdata;
    req_valid[i] = 1'b1;
    if (hold_rr) resp_ready[i] = 1'b1;
    t = 0;
    while (!req_ready[i] && t < 200) begin @(negedge clk); t++; end
    if (!req_ready[i]) begin
      chk({tag, " accept timeout"}, 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    t = 0;
    while (!resp_valid[i] && t < 2000) begin @(negedge clk); t++; end
    if (!resp_valid[i]) begin
      chk({tag, " resp timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, " rises"}, capq.size(), expq.size());
    mism = 0;
    for (int n = 0; n < expq.size() && n < capq.size(); n++)
      if (capq[n][7:4] !== expq[n][7:4] || (capq[n][3:0] & expq[n][7:4]) !== (expq[n][3:0] & expq[n][7:4]))
        mism++;
    chk({tag, " frame nibbles mismatched"}, mism, 0);
    chk({tag, " ce_n low clocks"}, lowcnt, expq.size() * 2 * dv);
    chk({tag, " rdata"}, resp_rdata[i], exp_rd);
    rdata = resp_rdata[i];
    if (wen) for (int k = 0; k < nb; k++) mem[i][8'(addr[7:0] + 8'(k))] = wdata[8*k +: 8];
    resp_ready[i] = 1'b1;
    @(posedge clk);
    #1 if (!hold_rr) resp_ready[i] = 1'b0;
    @(negedge clk);
    chk({tag, " resp_valid drop"}, resp_valid[i], 1'b0);
  endtask

  typedef struct {
    int          inst;
    logic        wen;
    logic [23:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t tbl[6];
    logic [31:0] rd;
    int t, rv;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_wen[i] = 0; req_addr[i] = '0; req_size[i] = '0;
      req_wdata[i] = '0; resp_ready[i] = 0;
      for (int a = 0; a < 256; a++) mem[i][a] = 8'($urandom);
    end
    mem[0][8'h10] = 8'h11; mem[0][8'h11] = 8'h22; mem[0][8'h12] = 8'h33; mem[0][8'h13] = 8'h44;

    tbl[0] = '{0, 1'b0, 24'h000010, 2'd2, 32'h0,          32'h44332211};
    tbl[1] = '{1, 1'b1, 24'h123456, 2'd0, 32'h000000A5,   32'h0};
    tbl[2] = '{1, 1'b0, 24'h123456, 2'd0, 32'h0,          32'h000000A5};
    tbl[3] = '{0, 1'b1, 24'h000020, 2'd1, 32'hBEEFCAFE,   32'h0};
    tbl[4] = '{0, 1'b0, 24'h000020, 2'd1, 32'h0,          32'h0000CAFE};
    tbl[5] = '{0, 1'b0, 24'h000010, 2'd3, 32'h0,          32'h44332211};

    // reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset sck", sck[i], 1'b0);
      chk("reset ce_n", ce_n[i], 1'b1);
      chk("reset dio_oe", dio_oe[i], 4'h0);
      chk("reset dio_o", dio_o[i], 4'h0);
      chk("reset resp_valid", resp_valid[i], 1'b0);
      chk("reset resp_rdata", resp_rdata[i], 32'h0);
      chk("reset req_ready", req_ready[i], 1'b0);
    end
    rst = 1'b0;
    #1 chk("req_ready right after release", req_ready[0], 1'b0);
    @(negedge clk);
    chk("req_ready one cycle after release", req_ready[0], 1'b1);
    chk("req_ready one cycle after release (div2)", req_ready[1], 1'b1);

    foreach (tbl[v]) begin
      txn(tbl[v].inst, tbl[v].wen, tbl[v].addr, tbl[v].size, tbl[v].wdata, 1'b0, $sformatf("vec%0d", v), rd);
      chk($sformatf("vec%0d table rdata", v), rd, tbl[v].exp_rd);
    end

    // back-to-back with resp_ready held high
    txn(1, 1'b0, 24'h000100, 2'd1, 32'h0, 1'b1, "b2b first", rd);
    txn(1, 1'b1, 24'h000104, 2'd0, 32'h5A, 1'b1, "b2b second", rd);
    resp_ready[1] = 1'b0;
    chk("b2b ce_n gap >= CE_GAP", (last_gap >= 3) ? 1 : 0, 1);
    act = 0;
    txn(0, 1'b0, 24'h000000, 2'd0, 32'h0, 1'b1, "b2b0 first", rd);
    txn(0, 1'b0, 24'h000001, 2'd0, 32'h0, 1'b1, "b2b0 second", rd);
    resp_ready[0] = 1'b0;
    chk("b2b0 ce_n gap >= CE_GAP", (last_gap >= 2) ? 1 : 0, 1);

    // reset in the middle of ADDR
    act = 0;
    @(negedge clk);
    capq.delete();
    req_wen[0] = 0; req_addr[0] = 24'h000010; req_size[0] = 2'd2; req_valid[0] = 1;
    t = 0;
    while (!req_ready[0] && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 req_valid[0] = 0;
    t = 0;
    while (capq.size() < 10 && t < 100) begin @(negedge clk); t++; end
    chk("mid reset reached ADDR", (capq.size() >= 10 && capq.size() <= 14) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    chk("mid reset ce_n", ce_n[0], 1'b1);
    chk("mid reset dio_oe", dio_oe[0], 4'h0);
    chk("mid reset sck", sck[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rv = 0;
    resp_ready[0] = 1'b0;
    repeat (30) begin @(negedge clk); if (resp_valid[0]) rv++; end
    chk("mid reset no resp", rv, 0);
    txn(0, 1'b0, 24'h000010, 2'd2, 32'h0, 1'b0, "after reset read", rd);

    // randomized traffic against the memory model
    for (int n = 0; n < 40; n++)
      txn(int'($urandom_range(1, 0)), 1'($urandom), 24'($urandom), 2'($urandom), $urandom,
          1'($urandom), $sformatf("rnd%0d", n), rd);
    resp_ready[0] = 0; resp_ready[1] = 0;

    chk("sck idle while ce_n high", bad_sck, 0);
    chk("req_ready low while busy", bad_rdy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
